// File: rtl/nios_switch_debounce_irq_pkg.sv
// Shared definitions for the switch debounce / edge-capture PIO.
//   - Avalon register addresses
//   - EDGE_TYPE encodings and the per-bit edge selector
//   - FSM state type (power-up settle window, then normal run)
package nios_switch_debounce_irq_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;  // debounced level
    localparam logic [1:0] ADDR_RAW  = 2'd1;  // synchronised raw pins
    localparam logic [1:0] ADDR_MASK = 2'd2;  // irq mask
    localparam logic [1:0] ADDR_EDGE = 2'd3;  // sticky edge capture, write-1-to-clear

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Edge selector for one bit: cur is the debounced level, prev its one-cycle delayed copy.
    function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
        case (edge_type)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/nios_switch_debounce_irq_bit.sv
// Single-bit switch conditioner: two-flop synchroniser, stable-tick counter
// and the accepted (debounced) level.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   pin         - raw asynchronous switch input
//   tick        - one-cycle prescaler pulse shared by all bits
//   sync        - pin after the two-flop synchroniser
//   debounced   - level accepted after DEBOUNCE_TICKS stable ticks
module switch_debounce_bit #(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic tick,
    output logic sync,
    output logic debounced
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] stable_cnt;

    // Stage p0/p1: metastability filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

    assign sync = sync_p1;

    // Debounce: any cycle where the input agrees with the accepted level
    // throws away the progress, so only an uninterrupted run of ticks counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            debounced  <= 1'b0;
        end else if (sync_p1 == debounced) begin
            stable_cnt <= '0;
        end else if (tick) begin
            if (stable_cnt == CNT_LAST) begin
                debounced  <= sync_p1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios_switch_debounce_irq.sv
// Avalon-MM switch PIO with per-bit debounce, sticky edge capture and a
// maskable level interrupt. Drop-in for the plain switch PIO: registered
// readdata, one-cycle read latency, no wait states.
// Ports:
//   clk, reset       - system clock, asynchronous active-high reset
//   address          - 0 debounced, 1 raw sync, 2 irq mask, 3 edge capture (W1C)
//   chipselect       - slave select
//   write_n          - active-low write strobe, qualified by chipselect
//   writedata        - write data (low WIDTH bits used)
//   in_port          - raw switch pins
//   readdata         - registered read data, bits above WIDTH are zero
//   irq              - level interrupt, |(edge_capture & irq_mask) registered
module nios_switch_debounce_irq
    import nios_switch_debounce_irq_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int EDGE_TYPE      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int SET_W = $clog2(DEBOUNCE_TICKS + 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    state_t           state;
    state_t           state_next;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_cnt_next;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_p1;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_mux;
    logic             wr;

    // Shared debounce time base
    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Settle window: one tick longer than the debounce period, so levels
    // present at power-up are absorbed before edge capture is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SETTLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        case (state)
            SETTLE: begin
                if (tick) begin
                    if (settle_cnt == SET_W'(DEBOUNCE_TICKS)) begin
                        state_next      = RUN;
                        settle_cnt_next = '0;
                    end else begin
                        settle_cnt_next = settle_cnt + 1'b1;
                    end
                end
            end
            RUN:     state_next = RUN;
            default: state_next = SETTLE;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .pin       (in_port[i]),
            .tick      (tick),
            .sync      (sync[i]),
            .debounced (debounced[i])
        );
        assign edge_det[i] = edge_hit(EDGE_TYPE, debounced[i], debounced_p1[i]);
    end

    assign wr      = chipselect & ~write_n;
    assign cap_set = (state == RUN) ? edge_det : '0;
    assign cap_clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = debounced;
            ADDR_RAW:  rd_mux = sync;
            ADDR_MASK: rd_mux = irq_mask;
            ADDR_EDGE: rd_mux = edge_capture;
            default:   rd_mux = '0;
        endcase
    end

    // Register stage: capture (set beats clear), mask, read data, irq
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced_p1 <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            debounced_p1 <= debounced;
            edge_capture <= (edge_capture & ~cap_clr) | cap_set;
            if (wr && address == ADDR_MASK)
                irq_mask <= writedata[WIDTH-1:0];
            readdata     <= 32'(rd_mux);
            irq          <= |(edge_capture & irq_mask);
        end
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_nios_switch_debounce_irq.sv
// Directed bench for nios_switch_debounce_irq with TICK_DIV=4,
// DEBOUNCE_TICKS=3, EDGE_TYPE=2 (any edge).
module tb_nios_switch_debounce_irq;
    import nios_switch_debounce_irq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    nios_switch_debounce_irq #(
        .WIDTH          (8),
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .EDGE_TYPE      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Edges since reset release; ticks are sampled on edges where cyc % 4 == 0.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        d          = readdata;
    endtask

    task automatic align4();
        while (cyc % 4 != 0) step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          k;
        bit          found;

        reset      = 1'b1;
        in_port    = 8'hFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ADDR_DATA;
        writedata  = '0;
        step(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", irq, 32'h0);

        // Power-up with all switches high: deb at edge 12, visible on edge 13
        reset = 1'b0;
        found = 0;
        k     = 0;
        for (int i = 1; i <= 30 && !found; i++) begin
            step(1);
            k = i;
            if (readdata == 32'hFF) found = 1;
        end
        check("pwr_reg0", readdata, 32'hFF);
        check("pwr_reg0_cycles", k, 13);
        while (cyc < 24) step(1);
        bus_read(ADDR_EDGE, rd);
        check("settle_no_capture", rd, 32'h0);
        check("settle_no_irq", irq, 32'h0);

        // Falling edges on all bits are captured in RUN
        in_port = 8'h00;
        step(20);
        bus_read(ADDR_DATA, rd);
        check("fall_reg0", rd, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("fall_reg3", rd, 32'hFF);
        check("fall_irq_masked", irq, 32'h0);
        bus_write(ADDR_EDGE, 32'hFF);
        bus_read(ADDR_EDGE, rd);
        check("w1c_all", rd, 32'h0);
        bus_write(ADDR_MASK, 32'h01);
        bus_read(ADDR_MASK, rd);
        check("mask_rd", rd, 32'h01);

        // Bit0 rises: debounced after 11..14 edges, plus one for the read register
        address = ADDR_DATA;
        in_port = 8'h01;
        found   = 0;
        k       = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            step(1);
            k = i;
            if (readdata[0]) found = 1;
        end
        check("rise_found", found, 32'h1);
        check("rise_window", (k >= 12 && k <= 15), 32'h1);
        check("rise_irq_lag", irq, 32'h0);
        step(1);
        check("rise_irq", irq, 32'h1);
        bus_read(ADDR_EDGE, rd);
        check("rise_reg3", rd, 32'h01);

        // Short glitches on bit3 never reach three ticks
        in_port = 8'h09; step(1); in_port = 8'h01; step(3);
        in_port = 8'h09; step(5); in_port = 8'h01; step(20);
        bus_read(ADDR_DATA, rd);
        check("glitch_reg0", rd, 32'h01);
        bus_read(ADDR_EDGE, rd);
        check("glitch_reg3", rd, 32'h01);
        check("glitch_irq", irq, 32'h1);

        // Clear bit0, then collide a clear with a new edge: set wins
        bus_write(ADDR_EDGE, 32'h01);
        bus_read(ADDR_EDGE, rd);
        check("clr0_reg3", rd, 32'h0);
        check("clr0_irq", irq, 32'h0);
        align4();
        in_port = 8'h00;   // deb falls on edge +12, edge_det high until +13
        step(12);
        bus_write(ADDR_EDGE, 32'h01);
        bus_read(ADDR_EDGE, rd);
        check("set_wins_reg3", rd, 32'h01);
        check("set_wins_irq", irq, 32'h1);
        bus_write(ADDR_EDGE, 32'h01);
        check("clr_irq_hold", irq, 32'h1);
        step(1);
        check("clr_irq_drop", irq, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("clr_reg3", rd, 32'h0);

        // Pending capture on bit2 gated by the mask
        bus_write(ADDR_MASK, 32'h0);
        in_port = 8'h04;
        step(20);
        bus_read(ADDR_EDGE, rd);
        check("p2_reg3", rd, 32'h04);
        check("p2_irq_masked", irq, 32'h0);
        bus_write(ADDR_MASK, 32'h04);
        check("mask_on_lag", irq, 32'h0);
        step(1);
        check("mask_on_irq", irq, 32'h1);
        bus_write(ADDR_MASK, 32'h0);
        check("mask_off_lag", irq, 32'h1);
        step(1);
        check("mask_off_irq", irq, 32'h0);
        address = ADDR_MASK; writedata = 32'h04; chipselect = 1'b0; write_n = 1'b0;
        step(1);
        write_n = 1'b1;
        step(1);
        check("nocs_ignored", irq, 32'h0);
        bus_write(ADDR_MASK, 32'h04);
        step(1);

        // Reset in the middle of a bit5 count (counter at 2 after edge +8)
        address = ADDR_EDGE;
        align4();
        in_port = 8'h24;
        step(9);
        check("pre_rst_readdata", readdata, 32'h04);
        check("pre_rst_irq", irq, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid_readdata", readdata, 32'h0);
        check("rst_mid_irq", irq, 32'h0);
        step(2);
        reset = 1'b0;
        step(3);
        bus_read(ADDR_RAW, rd);
        check("rst_raw", rd, 32'h24);
        bus_read(ADDR_DATA, rd);
        check("rst_deb_pending", rd, 32'h0);
        while (cyc < 24) step(1);
        bus_read(ADDR_DATA, rd);
        check("rst_reg0", rd, 32'h24);
        bus_read(ADDR_EDGE, rd);
        check("rst_reg3", rd, 32'h0);
        bus_read(ADDR_MASK, rd);
        check("rst_reg2", rd, 32'h0);
        check("rst_irq_after", irq, 32'h0);
        in_port = 8'h04;
        step(20);
        bus_read(ADDR_EDGE, rd);
        check("run_again_reg3", rd, 32'h20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
